pipe_stage_skid_reg: RTL and testbench

- Parametrised successor to the fixed-width stage registers between pipeline stages (IF/ID/EXE/MEM).
- Carries a packed control and data bundle of WIDTH bits.
- Adds valid/ready handshaking and a 2-entry skid buffer, so upstream ready is registered and full throughput holds under downstream back-pressure.
- Keeps the existing flush and freeze semantics, in one-clock, synchronous-reset form.

---
 rtl/pipe_stage_skid_reg_if.sv | 28 ++
 rtl/pipe_stage_skid_reg.sv | 83 ++++++++
 tb/tb_pipe_stage_skid_reg.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_reg_if.sv
// ============================================================================
// Module   : pipe_stage_skid_reg_if
// Brief    : Valid/ready/data handshake bundle for a pipeline stage boundary.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pipe_stage_skid_reg_if #(
    parameter int WIDTH = 158
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_skid_reg.sv
// ============================================================================
// Module   : pipe_stage_skid_reg
// Brief    : Pipeline stage register with valid/ready handshake and a 2-entry
//            skid buffer. Upstream ready is a function of registered state
//            and freeze only. Optional macro PIPE_STAGE_SKID_ZERO_ON_FLUSH_EN
//            makes flush also load RESET_DATA into both data registers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_skid_reg #(
    parameter int               WIDTH      = 158,
    parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{1'b0}}
) (
    input  wire                         clk,
    input  wire                         rst,
    input  wire                         flush,
    input  wire                         freeze,
    pipe_stage_skid_reg_if.slave        up,
    pipe_stage_skid_reg_if.master       dn,
    output logic [1:0]                  occupancy
);

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_in_fire;
    logic             w_out_fire;

    // Skid occupancy alone gates upstream, so in_ready never sees out_ready.
    assign w_in_ready  = !r_skid_valid && !freeze;
    assign w_out_valid = r_main_valid && !freeze;
    assign w_in_fire   = up.valid && w_in_ready;
    assign w_out_fire  = w_out_valid && dn.ready;

    assign up.ready  = w_in_ready;
    assign dn.valid  = w_out_valid;
    assign dn.data   = r_main_data;
    assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= RESET_DATA;
            r_skid_data  <= RESET_DATA;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
`ifdef PIPE_STAGE_SKID_ZERO_ON_FLUSH_EN
            r_main_data  <= RESET_DATA;
            r_skid_data  <= RESET_DATA;
`endif
        end else if (!freeze) begin
            if (w_out_fire) begin
                if (r_skid_valid) begin
                    // TWO -> ONE: the skid entry is the next beat in order.
                    r_main_data  <= r_skid_data;
                    r_skid_valid <= 1'b0;
                end else if (w_in_fire) begin
                    r_main_data  <= up.data;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                if (r_main_valid) begin
                    r_skid_data  <= up.data;
                    r_skid_valid <= 1'b1;
                end else begin
                    r_main_data  <= up.data;
                    r_main_valid <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
// ============================================================================
// Module   : tb_pipe_stage_skid_reg
// Brief    : Directed vector table plus a queue-modelled handshake sequence.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid_reg;

    localparam int W = 158;
`ifdef PIPE_STAGE_SKID_ZERO_ON_FLUSH_EN
    localparam logic [15:0] FLUSH_DATA = 16'h0000;
`else
    localparam logic [15:0] FLUSH_DATA = 16'h0005;
`endif

    typedef struct {
        logic        rst;
        logic        flush;
        logic        freeze;
        logic        in_valid;
        logic [15:0] in_data;
        logic        out_ready;
        logic        chk;
        logic        exp_out_valid;
        logic        exp_in_ready;
        logic [1:0]  exp_occ;
        logic [15:0] exp_data;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       freeze;
    logic [1:0] occupancy;

    pipe_stage_skid_reg_if #(.WIDTH(W)) up_if ();
    pipe_stage_skid_reg_if #(.WIDTH(W)) dn_if ();

    pipe_stage_skid_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .freeze    (freeze),
        .up        (up_if),
        .dn        (dn_if),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total;
    int   bad;
    vec_t vecs[$];

    function automatic void add(input logic r, input logic fl, input logic fz,
                                input logic iv, input logic [15:0] d, input logic ordy,
                                input logic c, input logic eov, input logic eir,
                                input logic [1:0] eocc, input logic [15:0] ed);
        vec_t v;
        v.rst = r; v.flush = fl; v.freeze = fz; v.in_valid = iv; v.in_data = d;
        v.out_ready = ordy; v.chk = c; v.exp_out_valid = eov; v.exp_in_ready = eir;
        v.exp_occ = eocc; v.exp_data = ed;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [39:0] iv_pat;
        logic [39:0] or_pat;
        logic [15:0] q[$];
        logic [15:0] next_val;
        logic        in_f;
        logic        out_f;

        total = 0; bad = 0;
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
        up_if.valid = 1'b0; up_if.data = '0; dn_if.ready = 1'b0;

        //   rst fl fz iv data     or chk ov ir occ exp
        add(0, 0, 0, 0, 16'h0,  0, 0, 0, 1, 0, 16'h0);
        add(0, 0, 0, 0, 16'h0,  0, 1, 0, 1, 0, 16'h0);
        add(1, 0, 0, 0, 16'h0,  1, 1, 0, 1, 0, 16'h0);
        // streaming 1..4
        add(1, 0, 0, 1, 16'h1,  1, 1, 0, 1, 0, 16'h0);
        add(1, 0, 0, 1, 16'h2,  1, 1, 1, 1, 1, 16'h1);
        add(1, 0, 0, 1, 16'h3,  1, 1, 1, 1, 1, 16'h2);
        add(1, 0, 0, 1, 16'h4,  1, 1, 1, 1, 1, 16'h3);
        add(1, 0, 0, 0, 16'h0,  1, 1, 1, 1, 1, 16'h4);
        add(1, 0, 0, 0, 16'h0,  1, 1, 0, 1, 0, 16'h4);
        // back-pressure into the skid entry
        add(1, 0, 0, 1, 16'hA,  0, 1, 0, 1, 0, 16'h4);
        add(1, 0, 0, 1, 16'hB,  0, 1, 1, 1, 1, 16'hA);
        add(1, 0, 0, 1, 16'hC,  0, 1, 1, 0, 2, 16'hA);
        add(1, 0, 0, 0, 16'h0,  1, 1, 1, 0, 2, 16'hA);
        add(1, 0, 0, 0, 16'h0,  1, 1, 1, 1, 1, 16'hB);
        add(1, 0, 0, 0, 16'h0,  1, 1, 0, 1, 0, 16'hB);
        // freeze with two held entries
        add(1, 0, 0, 1, 16'hA,  0, 1, 0, 1, 0, 16'hB);
        add(1, 0, 0, 1, 16'hB,  0, 1, 1, 1, 1, 16'hA);
        add(1, 0, 1, 1, 16'hC,  1, 1, 0, 0, 2, 16'hA);
        add(1, 0, 1, 1, 16'hC,  1, 1, 0, 0, 2, 16'hA);
        add(1, 0, 1, 1, 16'hC,  1, 1, 0, 0, 2, 16'hA);
        add(1, 0, 0, 1, 16'hC,  1, 1, 1, 0, 2, 16'hA);
        add(1, 0, 0, 1, 16'hC,  1, 1, 1, 1, 1, 16'hB);
        add(1, 0, 0, 0, 16'h0,  1, 1, 1, 1, 1, 16'hC);
        add(1, 0, 0, 0, 16'h0,  1, 1, 0, 1, 0, 16'hC);
        // flush racing both handshakes
        add(1, 0, 0, 1, 16'h5,  0, 1, 0, 1, 0, 16'hC);
        add(1, 1, 0, 1, 16'h6,  1, 1, 1, 1, 1, 16'h5);
        add(1, 0, 0, 0, 16'h0,  1, 1, 0, 1, 0, FLUSH_DATA);
        add(1, 0, 0, 0, 16'h0,  1, 1, 0, 1, 0, FLUSH_DATA);
        // reset overriding freeze with two held entries
        add(1, 0, 0, 1, 16'hA,  0, 1, 0, 1, 0, FLUSH_DATA);
        add(1, 0, 0, 1, 16'hB,  0, 1, 1, 1, 1, 16'hA);
        add(0, 0, 1, 1, 16'hC,  0, 1, 0, 0, 2, 16'hA);
        add(1, 0, 1, 0, 16'h0,  0, 1, 0, 0, 0, 16'h0);
        add(1, 0, 0, 0, 16'h0,  1, 1, 0, 1, 0, 16'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; flush = vecs[i].flush; freeze = vecs[i].freeze;
            up_if.valid = vecs[i].in_valid;
            up_if.data  = W'(vecs[i].in_data);
            dn_if.ready = vecs[i].out_ready;
            #1;
            if (vecs[i].chk) begin
                check("out_valid", i, W'(dn_if.valid), W'(vecs[i].exp_out_valid));
                check("in_ready",  i, W'(up_if.ready), W'(vecs[i].exp_in_ready));
                check("occupancy", i, W'(occupancy),   W'(vecs[i].exp_occ));
                check("out_data",  i, dn_if.data,      W'(vecs[i].exp_data));
            end
        end

        // Irregular valid/ready mix against a 2-deep FIFO reference.
        iv_pat   = 40'b0011_1111_0110_1101_1111_1010_1111_0111_1101_1011;
        or_pat   = 40'b1111_1000_1110_0101_1100_0011_1010_0001_1101_0110;
        next_val = 16'h100;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rst = 1'b1; flush = 1'b0; freeze = 1'b0;
            up_if.valid = iv_pat[c];
            up_if.data  = W'(next_val);
            dn_if.ready = or_pat[c];
            #1;
            check("seq_occupancy", c, W'(occupancy),   W'(q.size()));
            check("seq_in_ready",  c, W'(up_if.ready), W'(q.size() < 2));
            check("seq_out_valid", c, W'(dn_if.valid), W'(q.size() != 0));
            if (q.size() != 0)
                check("seq_out_data", c, dn_if.data, W'(q[0]));
            in_f  = iv_pat[c] && (q.size() < 2);
            out_f = or_pat[c] && (q.size() != 0);
            if (out_f) void'(q.pop_front());
            if (in_f) begin
                q.push_back(next_val);
                next_val = next_val + 16'h1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
